// File: rtl/spi_pkg.sv
// Shared types for the SPI mode-0 peripheral: frame state encoding and word indexing.
package spi_pkg;

    localparam int SPI_WORDS = 4;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2,
        OVERFLOW  = 2'd3
    } spi_per_state_t;

    // Counts 0..SPI_WORDS; saturates at SPI_WORDS once a frame is full.
    typedef logic [2:0] word_idx_t;

    localparam word_idx_t WORD_IDX_LAST = 3'd3;
    localparam word_idx_t WORD_IDX_MAX  = 3'd4;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin plus registered single-clk
// rise/fall pulses. Latency from pin change to pulse is SYNC_STAGES+1 clk.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchronizer chain, delayed copy for edge detection, and registered edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[SYNC_STAGES-1] & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder oversampled by clk: exchanges up to four MSB-first
// words per SS-low frame, returning tx_word0..3 and capturing rx_word0..3.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCK,
    input  logic                 SS,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] tx_word0,
    input  logic [DATA_BITS-1:0] tx_word1,
    input  logic [DATA_BITS-1:0] tx_word2,
    input  logic [DATA_BITS-1:0] tx_word3,
    output logic [DATA_BITS-1:0] rx_word0,
    output logic [DATA_BITS-1:0] rx_word1,
    output logic [DATA_BITS-1:0] rx_word2,
    output logic [DATA_BITS-1:0] rx_word3,
    output logic                 rx_valid,
    output logic [1:0]           rx_index,
    output logic                 frame_active,
    output logic                 frame_done,
    output logic [2:0]           word_count,
    output logic                 overrun
);

    localparam int                 BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);

    spi_per_state_t         state_r, next_state_s;
    logic                   sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   mosi_s;

    logic [DATA_BITS-1:0] tx_in_s    [SPI_WORDS];
    logic [DATA_BITS-1:0] tx_words_r [SPI_WORDS];
    logic [DATA_BITS-1:0] rx_words_r [SPI_WORDS];
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic [DATA_BITS-2:0] rx_shift_r, rx_shift_s;
    logic [DATA_BITS-1:0] rx_word_s;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
    word_idx_t            word_idx_r, word_idx_s;
    logic                 load_pend_r, load_pend_s;
    logic [2:0]           word_count_r, word_count_s;
    logic                 overrun_r, overrun_s;
    logic [1:0]           rx_index_r, rx_index_s;
    logic                 rx_valid_r, rx_valid_s;
    logic                 frame_done_r, frame_done_s;
    logic                 frame_active_r;
    logic                 miso_r, miso_s;
    logic                 rx_we_s, tx_latch_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SCK),
        .rise  (sck_rise_s),
        .fall  (sck_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SS),
        .rise  (ss_rise_s),
        .fall  (ss_fall_s)
    );

    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign tx_in_s[0] = tx_word0;
    assign tx_in_s[1] = tx_word1;
    assign tx_in_s[2] = tx_word2;
    assign tx_in_s[3] = tx_word3;

    // Next-state and datapath decode; ss_rise outranks any SCK edge on the same clk.
    always_comb begin
        next_state_s = state_r;
        tx_shift_s   = tx_shift_r;
        rx_word_s    = {rx_shift_r, mosi_s};
        rx_shift_s   = rx_shift_r;
        bit_cnt_s    = bit_cnt_r;
        word_idx_s   = word_idx_r;
        load_pend_s  = load_pend_r;
        word_count_s = word_count_r;
        overrun_s    = overrun_r;
        rx_index_s   = rx_index_r;
        rx_valid_s   = 1'b0;
        frame_done_s = 1'b0;
        rx_we_s      = 1'b0;
        tx_latch_s   = 1'b0;
        case (state_r)
            // The synchronizer resets low, so an idle-high SS always shows up as ss_rise.
            WAIT_IDLE: begin
                if (ss_rise_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_IDLE;
                end
            end
            IDLE: begin
                if (ss_fall_s) begin
                    next_state_s = ACTIVE;
                    tx_latch_s   = 1'b1;
                    tx_shift_s   = tx_word0;
                    rx_shift_s   = {(DATA_BITS-1){1'b0}};
                    bit_cnt_s    = {BIT_W{1'b0}};
                    word_idx_s   = 3'd0;
                    word_count_s = 3'd0;
                    overrun_s    = 1'b0;
                    load_pend_s  = 1'b0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    next_state_s = IDLE;
                    frame_done_s = 1'b1;
                end else if (sck_rise_s) begin
                    rx_shift_s = rx_word_s[DATA_BITS-2:0];
                    if (bit_cnt_r == BIT_LAST) begin
                        rx_we_s      = 1'b1;
                        rx_valid_s   = 1'b1;
                        rx_index_s   = word_idx_r[1:0];
                        word_count_s = word_count_r + 3'd1;
                        bit_cnt_s    = {BIT_W{1'b0}};
                        load_pend_s  = 1'b1;
                        if (word_idx_r == WORD_IDX_MAX) begin
                            word_idx_s = WORD_IDX_MAX;
                        end else begin
                            word_idx_s = word_idx_r + 3'd1;
                        end
                        if (word_idx_r == WORD_IDX_LAST) begin
                            next_state_s = OVERFLOW;
                        end else begin
                            next_state_s = ACTIVE;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else if (sck_fall_s) begin
                    if (load_pend_r) begin
                        tx_shift_s  = tx_words_r[word_idx_r[1:0]];
                        load_pend_s = 1'b0;
                    end else begin
                        tx_shift_s = {tx_shift_r[DATA_BITS-2:0], 1'b0};
                    end
                end else begin
                    next_state_s = ACTIVE;
                end
            end
            OVERFLOW: begin
                if (ss_rise_s) begin
                    next_state_s = IDLE;
                    frame_done_s = 1'b1;
                end else if (sck_rise_s) begin
                    overrun_s = 1'b1;
                end else begin
                    next_state_s = OVERFLOW;
                end
            end
            default: begin
                next_state_s = WAIT_IDLE;
            end
        endcase
        if (next_state_s == ACTIVE) begin
            miso_s = tx_shift_s[DATA_BITS-1];
        end else begin
            miso_s = 1'b0;
        end
    end

    // State, shift registers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= WAIT_IDLE;
            mosi_sync_r    <= {SYNC_STAGES{1'b0}};
            tx_shift_r     <= {DATA_BITS{1'b0}};
            rx_shift_r     <= {(DATA_BITS-1){1'b0}};
            bit_cnt_r      <= {BIT_W{1'b0}};
            word_idx_r     <= 3'd0;
            load_pend_r    <= 1'b0;
            word_count_r   <= 3'd0;
            overrun_r      <= 1'b0;
            rx_index_r     <= 2'd0;
            rx_valid_r     <= 1'b0;
            frame_done_r   <= 1'b0;
            frame_active_r <= 1'b0;
            miso_r         <= 1'b0;
            for (int i = 0; i < SPI_WORDS; i++) begin
                tx_words_r[i] <= {DATA_BITS{1'b0}};
                rx_words_r[i] <= {DATA_BITS{1'b0}};
            end
        end else begin
            state_r        <= next_state_s;
            mosi_sync_r    <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            tx_shift_r     <= tx_shift_s;
            rx_shift_r     <= rx_shift_s;
            bit_cnt_r      <= bit_cnt_s;
            word_idx_r     <= word_idx_s;
            load_pend_r    <= load_pend_s;
            word_count_r   <= word_count_s;
            overrun_r      <= overrun_s;
            rx_index_r     <= rx_index_s;
            rx_valid_r     <= rx_valid_s;
            frame_done_r   <= frame_done_s;
            frame_active_r <= (next_state_s == ACTIVE);
            miso_r         <= miso_s;
            if (tx_latch_s) begin
                tx_words_r <= tx_in_s;
            end
            if (rx_we_s) begin
                rx_words_r[word_idx_r[1:0]] <= rx_word_s;
            end
        end
    end

    assign MISO         = miso_r;
    assign rx_word0     = rx_words_r[0];
    assign rx_word1     = rx_words_r[1];
    assign rx_word2     = rx_words_r[2];
    assign rx_word3     = rx_words_r[3];
    assign rx_valid     = rx_valid_r;
    assign rx_index     = rx_index_r;
    assign frame_active = frame_active_r;
    assign frame_done   = frame_done_r;
    assign word_count   = word_count_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench acting as an SPI mode-0 controller; received words are checked
// by a monitor against a queue of expected {index, data} pairs.
module tb_spi_peripheral;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       reset, SCK, SS, MOSI, MISO;
    logic [7:0] tx_word0, tx_word1, tx_word2, tx_word3;
    logic [7:0] rx_word0, rx_word1, rx_word2, rx_word3;
    logic       rx_valid, frame_active, frame_done, overrun;
    logic [1:0] rx_index;
    logic [2:0] word_count;

    int         n_vec = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic [9:0] exp_q[$];
    logic [7:0] miso_words [5];
    logic [7:0] rx_sel;

    spi_peripheral #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .tx_word0(tx_word0), .tx_word1(tx_word1), .tx_word2(tx_word2), .tx_word3(tx_word3),
        .rx_word0(rx_word0), .rx_word1(rx_word1), .rx_word2(rx_word2), .rx_word3(rx_word3),
        .rx_valid(rx_valid), .rx_index(rx_index), .frame_active(frame_active),
        .frame_done(frame_done), .word_count(word_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (rx_index)
            2'd0:    rx_sel = rx_word0;
            2'd1:    rx_sel = rx_word1;
            2'd2:    rx_sel = rx_word2;
            default: rx_sel = rx_word3;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_tx(input logic [31:0] w);
        {tx_word0, tx_word1, tx_word2, tx_word3} = w;
    endtask

    // Monitor: pops an expectation for every rx_valid pulse and counts frame_done pulses.
    always @(negedge clk) begin
        logic [9:0] e;
        if (frame_done) done_cnt++;
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rx_valid_unexpected: got index %0d word %0h expected no pulse", rx_index, rx_sel);
            end else begin
                e = exp_q.pop_front();
                check("rx_index", {30'd0, rx_index}, {30'd0, e[9:8]});
                check("rx_word", {24'd0, rx_sel}, {24'd0, e[7:0]});
            end
        end
    end

    // act: 0 none, 1 pulse reset before bit act_bit, 2 zero all tx_word* before bit act_bit.
    task automatic spi_frame(input logic [39:0] mosi_bits, input int nbits,
                             input int act, input int act_bit, input int gap);
        for (int w = 0; w < 5; w++) miso_words[w] = 8'h00;
        SS = 1'b0;
        repeat (8) @(negedge clk);
        check("frame_active_start", {31'd0, frame_active}, 32'd1);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < nbits; i++) begin
            if (i == act_bit && act == 1) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                check("midreset_flags", {24'd0, MISO, frame_active, overrun, rx_valid, frame_done, word_count},
                      32'd0);
                check("midreset_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'd0);
            end
            if (i == act_bit && act == 2) set_tx(32'h0000_0000);
            MOSI = mosi_bits[39-i];
            repeat (HALF) @(negedge clk);
            miso_words[i/8] = {miso_words[i/8][6:0], MISO};
            SCK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        SS = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; SS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        set_tx(32'hFAFB_FCFE);
        repeat (4) @(negedge clk);
        check("reset_flags", {21'd0, MISO, rx_valid, frame_active, frame_done, overrun, rx_index, word_count},
              32'd0);
        check("reset_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Short frame: one full word then four bits of a partial word.
        exp_q.push_back({2'd0, 8'h11});
        spi_frame({8'h11, 8'h22, 24'h0}, 12, 0, 0, 8);
        check("short_miso_w0", {24'd0, miso_words[0]}, 32'h0000_00FA);
        check("short_miso_w1_partial", {24'd0, miso_words[1]}, 32'h0000_000F);
        check("short_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'h1100_0000);
        check("short_word_count", {29'd0, word_count}, 32'd1);
        check("short_frame_done", done_cnt, 32'd1);
        check("short_miso_idle", {31'd0, MISO}, 32'd0);

        // Nominal four-word frame.
        exp_q.push_back({2'd0, 8'h3C}); exp_q.push_back({2'd1, 8'hA5});
        exp_q.push_back({2'd2, 8'h5A}); exp_q.push_back({2'd3, 8'hC3});
        spi_frame({32'h3CA5_5AC3, 8'h00}, 32, 0, 0, 8);
        check("nominal_miso", {miso_words[0], miso_words[1], miso_words[2], miso_words[3]}, 32'hFAFB_FCFE);
        check("nominal_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'h3CA5_5AC3);
        check("nominal_word_count", {29'd0, word_count}, 32'd4);
        check("nominal_overrun", {31'd0, overrun}, 32'd0);
        check("nominal_frame_done", done_cnt, 32'd2);
        check("nominal_frame_active_after", {31'd0, frame_active}, 32'd0);

        // Overrun: a fifth word is discarded and MISO stays low during it.
        exp_q.push_back({2'd0, 8'h11}); exp_q.push_back({2'd1, 8'h22});
        exp_q.push_back({2'd2, 8'h33}); exp_q.push_back({2'd3, 8'h44});
        spi_frame({32'h1122_3344, 8'h77}, 40, 0, 0, 8);
        check("ovr_miso", {miso_words[0], miso_words[1], miso_words[2], miso_words[3]}, 32'hFAFB_FCFE);
        check("ovr_miso_word5", {24'd0, miso_words[4]}, 32'd0);
        check("ovr_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'h1122_3344);
        check("ovr_overrun", {31'd0, overrun}, 32'd1);
        check("ovr_word_count", {29'd0, word_count}, 32'd4);
        check("ovr_frame_done", done_cnt, 32'd3);

        // Reset during word 1; the rest of that frame must be ignored.
        exp_q.push_back({2'd0, 8'h3C});
        spi_frame({32'h3CA5_5AC3, 8'h00}, 32, 1, 12, 8);
        check("rst_frame_done", done_cnt, 32'd3);
        check("rst_word_count", {29'd0, word_count}, 32'd0);
        check("rst_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'd0);

        // Recovery frame, then back-to-back frame with new tx words loaded while SS is high.
        exp_q.push_back({2'd0, 8'h5A}); exp_q.push_back({2'd1, 8'hC3});
        exp_q.push_back({2'd2, 8'h3C}); exp_q.push_back({2'd3, 8'hA5});
        spi_frame({32'h5AC3_3CA5, 8'h00}, 32, 0, 0, 0);
        set_tx(32'h0102_0304);
        repeat (4) @(negedge clk);
        check("recover_miso", {miso_words[0], miso_words[1], miso_words[2], miso_words[3]}, 32'hFAFB_FCFE);
        check("recover_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'h5AC3_3CA5);
        exp_q.push_back({2'd0, 8'h96}); exp_q.push_back({2'd1, 8'h69});
        exp_q.push_back({2'd2, 8'hF0}); exp_q.push_back({2'd3, 8'h0F});
        spi_frame({32'h9669_F00F, 8'h00}, 32, 0, 0, 8);
        check("b2b_miso", {miso_words[0], miso_words[1], miso_words[2], miso_words[3]}, 32'h0102_0304);
        check("b2b_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'h9669_F00F);
        check("b2b_frame_done", done_cnt, 32'd5);

        // tx_word* cleared mid-frame must not affect the words latched at frame start.
        set_tx(32'hFAFB_FCFE);
        exp_q.push_back({2'd0, 8'h12}); exp_q.push_back({2'd1, 8'h34});
        exp_q.push_back({2'd2, 8'h56}); exp_q.push_back({2'd3, 8'h78});
        spi_frame({32'h1234_5678, 8'h00}, 32, 2, 10, 8);
        check("txhold_miso", {miso_words[0], miso_words[1], miso_words[2], miso_words[3]}, 32'hFAFB_FCFE);
        check("txhold_rx_words", {rx_word0, rx_word1, rx_word2, rx_word3}, 32'h1234_5678);
        check("txhold_frame_done", done_cnt, 32'd6);
        check("txhold_word_count", {29'd0, word_count}, 32'd4);

        repeat (4) @(negedge clk);
        check("expected_queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
